// File: rtl/window_gen_3x3.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 shift window.
// Presents all nine taps of each complete in-image window one clock after its newest pixel.
module window_gen_3x3 #(
    parameter int DATA_WIDHT = 32,
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDHT-1:0] Data_In,
    input  logic                  Valid_In,
    output logic [DATA_WIDHT-1:0] Data_Out0,
    output logic [DATA_WIDHT-1:0] Data_Out1,
    output logic [DATA_WIDHT-1:0] Data_Out2,
    output logic [DATA_WIDHT-1:0] Data_Out3,
    output logic [DATA_WIDHT-1:0] Data_Out4,
    output logic [DATA_WIDHT-1:0] Data_Out5,
    output logic [DATA_WIDHT-1:0] Data_Out6,
    output logic [DATA_WIDHT-1:0] Data_Out7,
    output logic [DATA_WIDHT-1:0] Data_Out8,
    output logic                  Valid_Out,
    output logic                  Frame_Done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    typedef logic [DATA_WIDHT-1:0] pixel_t;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          col_last;
    logic          row_last;
    logic          win_ok;

    pixel_t lb0 [IMG_WIDTH];
    pixel_t lb1 [IMG_WIDTH];
    pixel_t win_q [9];
    pixel_t win_d [9];
    pixel_t out_q [9];

    assign col_last = (col == CW'(IMG_WIDTH - 1));
    assign row_last = (row == RW'(IMG_HEIGHT - 1));
    assign win_ok   = Valid_In && (row >= RW'(2)) && (col >= CW'(2));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col <= '0;
            row <= '0;
        end else if (Valid_In) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // NOTE: line-buffer RAM has no reset; stale lines are never flagged valid because row<2 masks them.
    always_ff @(posedge clk) begin
        if (Valid_In) begin
            lb0[col] <= lb1[col];
            lb1[col] <= Data_In;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        win_d = win_q;
        for (int r = 0; r < 3; r++) begin
            win_d[3*r]     = win_q[3*r + 1];
            win_d[3*r + 1] = win_q[3*r + 2];
        end
        win_d[2] = lb0[col];
        win_d[5] = lb1[col];
        win_d[8] = Data_In;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_q      <= '{default: '0};
            out_q      <= '{default: '0};
            Valid_Out  <= 1'b0;
            Frame_Done <= 1'b0;
        end else begin
            Valid_Out  <= win_ok;
            Frame_Done <= win_ok && row_last && col_last;
            if (Valid_In) win_q <= win_d;
            // Outputs hold between windows; the shift window keeps moving underneath.
            if (win_ok) out_q <= win_d;
        end
    end

    assign Data_Out0 = out_q[0];
    assign Data_Out1 = out_q[1];
    assign Data_Out2 = out_q[2];
    assign Data_Out3 = out_q[3];
    assign Data_Out4 = out_q[4];
    assign Data_Out5 = out_q[5];
    assign Data_Out6 = out_q[6];
    assign Data_Out7 = out_q[7];
    assign Data_Out8 = out_q[8];

endmodule

// File: tb/tb_window_gen_3x3.sv
// Self-checking bench for window_gen_3x3: a 5x5 instance driven against an image-array model,
// and a 3x3 instance driven from a vector table of FP32 pixels.
module tb_window_gen_3x3;

    localparam int DW = 32;
    localparam int W  = 5;
    localparam int H  = 5;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [DW-1:0]        din;
    logic                 vin;
    logic [8:0][DW-1:0]   q;
    logic                 vo;
    logic                 fd;
    logic [DW-1:0]        din3;
    logic                 vin3;
    logic [8:0][DW-1:0]   q3;
    logic                 vo3;
    logic                 fd3;

    always #5 clk = ~clk;

    window_gen_3x3 #(.DATA_WIDHT(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .Data_In(din), .Valid_In(vin),
        .Data_Out0(q[0]), .Data_Out1(q[1]), .Data_Out2(q[2]),
        .Data_Out3(q[3]), .Data_Out4(q[4]), .Data_Out5(q[5]),
        .Data_Out6(q[6]), .Data_Out7(q[7]), .Data_Out8(q[8]),
        .Valid_Out(vo), .Frame_Done(fd)
    );

    window_gen_3x3 #(.DATA_WIDHT(DW), .IMG_WIDTH(3), .IMG_HEIGHT(3)) dut3 (
        .clk(clk), .rst(rst), .Data_In(din3), .Valid_In(vin3),
        .Data_Out0(q3[0]), .Data_Out1(q3[1]), .Data_Out2(q3[2]),
        .Data_Out3(q3[3]), .Data_Out4(q3[4]), .Data_Out5(q3[5]),
        .Data_Out6(q3[6]), .Data_Out7(q3[7]), .Data_Out8(q3[8]),
        .Valid_Out(vo3), .Frame_Done(fd3)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: the current frame stored as a 2D image; each window is read straight from it.
    logic [DW-1:0]      img [H][W];
    int                 mr, mc;
    logic [8:0][DW-1:0] exp_taps;
    int                 win_cnt, fd_cnt;

    task automatic model_reset();
        mr       = 0;
        mc       = 0;
        exp_taps = '0;
    endtask

    task automatic pix(input logic [DW-1:0] d, input logic v);
        logic ev;
        logic ef;
        din = d;
        vin = v;
        @(posedge clk);
        #1;
        ev = 1'b0;
        ef = 1'b0;
        if (v) begin
            img[mr][mc] = d;
            if (mr >= 2 && mc >= 2) begin
                ev = 1'b1;
                ef = (mr == H - 1) && (mc == W - 1);
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        exp_taps[3*i + j] = img[mr - 2 + i][mc - 2 + j];
            end
            mc++;
            if (mc == W) begin
                mc = 0;
                mr = (mr + 1) % H;
            end
        end
        check("valid_out", 32'(vo), 32'(ev));
        check("frame_done", 32'(fd), 32'(ef));
        for (int k = 0; k < 9; k++)
            check($sformatf("tap%0d", k), q[k], exp_taps[k]);
        if (vo) win_cnt++;
        if (fd) fd_cnt++;
        vin = 1'b0;
    endtask

    task automatic check_taps(input string name, input int base, input int offs [9]);
        for (int k = 0; k < 9; k++)
            check($sformatf("%s_tap%0d", name, k), q[k], 32'(base + offs[k]));
    endtask

    typedef struct {
        logic [31:0]        din;
        logic               vin;
        logic               exp_vo;
        logic               exp_fd;
        logic [8:0][31:0]   exp_q;
    } vec_t;

    vec_t tbl [12];

    localparam logic [8:0][31:0] ONE_TO_NINE = {
        32'h41100000, 32'h41000000, 32'h40e00000, 32'h40c00000, 32'h40a00000,
        32'h40800000, 32'h40400000, 32'h40000000, 32'h3f800000
    };

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        int first_offs [9];
        int last_offs  [9];
        int accepts;
        logic [8:0][31:0] floats;

        first_offs = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
        last_offs  = '{12, 13, 14, 17, 18, 19, 22, 23, 24};
        din  = '0; vin  = 1'b0;
        din3 = '0; vin3 = 1'b0;
        rst  = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid_out", 32'(vo), 32'd0);
        check("rst_frame_done", 32'(fd), 32'd0);
        for (int k = 0; k < 9; k++) check($sformatf("rst_tap%0d", k), q[k], 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Continuous frame 0..24
        win_cnt = 0; fd_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            pix(DW'(i), 1'b1);
            if (i == 12) check_taps("first_win", 0, first_offs);
        end
        check_taps("last_win", 0, last_offs);
        check("windows_cont", 32'(win_cnt), 32'd9);
        check("frame_done_cont", 32'(fd_cnt), 32'd1);

        // Valid_In toggling 1/0 each cycle, garbage data on idle cycles
        win_cnt = 0; fd_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            pix(DW'(i), 1'b1);
            pix(DW'($urandom), 1'b0);
        end
        check_taps("toggle_last", 0, last_offs);
        check("windows_toggle", 32'(win_cnt), 32'd9);
        check("frame_done_toggle", 32'(fd_cnt), 32'd1);

        // Two back-to-back frames
        win_cnt = 0; fd_cnt = 0;
        for (int i = 0; i < 25; i++) pix(DW'(i), 1'b1);
        for (int i = 0; i < 25; i++) begin
            pix(DW'(100 + i), 1'b1);
            if (i == 12) check_taps("frame2_first", 100, first_offs);
        end
        check("windows_b2b", 32'(win_cnt), 32'd18);
        check("frame_done_b2b", 32'(fd_cnt), 32'd2);

        // Asynchronous reset after index 17, then a clean restart
        for (int i = 0; i < 18; i++) pix(DW'(i), 1'b1);
        rst = 1'b0;
        #1;
        check("async_rst_valid_out", 32'(vo), 32'd0);
        for (int k = 0; k < 9; k++) check($sformatf("async_rst_tap%0d", k), q[k], 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        win_cnt = 0; fd_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            pix(DW'(i), 1'b1);
            if (i == 12) check_taps("restart_first", 0, first_offs);
        end
        check_taps("restart_last", 0, last_offs);
        check("windows_restart", 32'(win_cnt), 32'd9);
        check("frame_done_restart", 32'(fd_cnt), 32'd1);

        // Randomised data and gaps over four frames
        win_cnt = 0; fd_cnt = 0; accepts = 0;
        while (accepts < 4 * W * H) begin
            logic v;
            v = ($urandom_range(0, 9) < 7);
            if (v) accepts++;
            pix(DW'($urandom), v);
            if ($urandom_range(0, 19) == 0)
                repeat ($urandom_range(1, 6)) pix(DW'($urandom), 1'b0);
        end
        check("windows_random", 32'(win_cnt), 32'd36);
        check("frame_done_random", 32'(fd_cnt), 32'd4);

        // Minimum 3x3 frame of FP32 1.0..9.0 with gaps, table-driven
        floats = ONE_TO_NINE;
        for (int i = 0; i < 12; i++) begin
            tbl[i].din    = 32'hdeadbeef;
            tbl[i].vin    = 1'b0;
            tbl[i].exp_vo = 1'b0;
            tbl[i].exp_fd = 1'b0;
            tbl[i].exp_q  = '0;
        end
        for (int p = 0, i = 0; p < 9; p++, i++) begin
            if (p == 3 || p == 7) i++;
            tbl[i].din = floats[p];
            tbl[i].vin = 1'b1;
            if (p == 8) begin
                tbl[i].exp_vo = 1'b1;
                tbl[i].exp_fd = 1'b1;
            end
        end
        for (int i = 10; i < 12; i++) tbl[i].exp_q = floats;
        tbl[10].exp_q = floats;
        for (int i = 0; i < 12; i++) begin
            din3 = tbl[i].din;
            vin3 = tbl[i].vin;
            @(posedge clk);
            #1;
            check($sformatf("min_valid_out[%0d]", i), 32'(vo3), 32'(tbl[i].exp_vo));
            check($sformatf("min_frame_done[%0d]", i), 32'(fd3), 32'(tbl[i].exp_fd));
            for (int k = 0; k < 9; k++)
                check($sformatf("min_tap%0d[%0d]", k, i), q3[k], tbl[i].exp_q[k]);
        end
        vin3 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
